// File: rtl/uart_tx_scheduler_if.sv
// Bundle of signals between the scheduler, its two requesters (ALU result and
// register-file read data) and the UART transmitter.
//   alu_req/alu_data/alu_ack : 16-bit ALU result request, level req, 1-cycle ack
//   rf_req/rf_data/rf_ack    : 8-bit RF read-data request, level req, 1-cycle ack
//   tx_busy                  : UART_TX busy indication
//   tx_data_valid/tx_p_data  : byte handed to UART_TX (valid is a 1-cycle pulse)
//   sched_busy               : scheduler is not idle
// The slave modport is the scheduler's view; master is the surrounding system.
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic                  alu_req;
  logic [ALU_WIDTH-1:0]  alu_data;
  logic                  alu_ack;
  logic                  rf_req;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_ack;
  logic                  tx_busy;
  logic                  tx_data_valid;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  sched_busy;

  modport master (
    output alu_req, alu_data, rf_req, rf_data, tx_busy,
    input  alu_ack, rf_ack, tx_data_valid, tx_p_data, sched_busy
  );

  modport slave (
    input  alu_req, alu_data, rf_req, rf_data, tx_busy,
    output alu_ack, rf_ack, tx_data_valid, tx_p_data, sched_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding UART_TX from two requesters: the ALU result
// (two bytes, low byte first) and register-file read data (one byte). The
// winning payload is latched, acked, then issued one byte at a time. An issue
// that UART_TX does not acknowledge by raising tx_busy within START_TO cycles
// is retried with the same byte.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_tx_scheduler_if.slave (requests, acks, UART_TX handshake)
// All outputs are registered.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16,
  parameter int START_TO   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  localparam int TO_W = $clog2(START_TO + 1);

  state_t                 state_q, state_d;
  // 1 when ALU won the last grant, so RF wins the next tie.
  logic                   ptr_q, ptr_d;
  // Holding register; the byte being sent is always the low byte, the
  // register shifts down after each completed byte.
  logic [ALU_WIDTH-1:0]   hold_q, hold_d;
  logic [1:0]             bytes_left_q, bytes_left_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   alu_ack_q, alu_ack_d;
  logic                   rf_ack_q, rf_ack_d;
  logic                   txv_q, txv_d;
  logic [DATA_WIDTH-1:0]  txd_q, txd_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    bytes_left_d = bytes_left_q;
    to_cnt_d     = to_cnt_q;
    alu_ack_d    = 1'b0;
    rf_ack_d     = 1'b0;
    txv_d        = 1'b0;
    txd_d        = txd_q;

    case (state_q)
      IDLE: begin
        if (bus.alu_req && (!bus.rf_req || !ptr_q)) begin
          hold_d       = bus.alu_data;
          bytes_left_d = 2'd2;
          alu_ack_d    = 1'b1;
          ptr_d        = 1'b1;
          state_d      = ISSUE;
        end else if (bus.rf_req) begin
          hold_d       = ALU_WIDTH'(bus.rf_data);
          bytes_left_d = 2'd1;
          rf_ack_d     = 1'b1;
          ptr_d        = 1'b0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (!bus.tx_busy) begin
          txv_d    = 1'b1;
          txd_d    = hold_q[DATA_WIDTH-1:0];
          to_cnt_d = '0;
          state_d  = WAIT_START;
        end
      end

      // The pulse cycle itself counts as the first cycle without tx_busy.
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_W'(START_TO - 1)) begin
          state_d = ISSUE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          bytes_left_d = bytes_left_q - 2'd1;
          hold_d       = hold_q >> DATA_WIDTH;
          state_d      = (bytes_left_q == 2'd1) ? IDLE : ISSUE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered from the next state so sched_busy lines up with state_q.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      hold_q       <= '0;
      bytes_left_q <= '0;
      to_cnt_q     <= '0;
      alu_ack_q    <= 1'b0;
      rf_ack_q     <= 1'b0;
      txv_q        <= 1'b0;
      txd_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      bytes_left_q <= bytes_left_d;
      to_cnt_q     <= to_cnt_d;
      alu_ack_q    <= alu_ack_d;
      rf_ack_q     <= rf_ack_d;
      txv_q        <= txv_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_ack       = alu_ack_q;
  assign bus.rf_ack        = rf_ack_q;
  assign bus.tx_data_valid = txv_q;
  assign bus.tx_p_data     = txd_q;
  assign bus.sched_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a UART_TX responder model plus per-scenario
// tasks comparing observed grants and delivered bytes with a queue-based model.
module tb_uart_tx_scheduler;
  localparam int DW       = 8;
  localparam int AW       = 16;
  localparam int START_TO = 4;
  localparam int BUSY_CYC = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) bus ();

  uart_tx_scheduler #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .START_TO(START_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // UART_TX responder and observation logs
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  int         busy_cnt   = 0;
  int         ignore_cnt = 0;
  int         cyc        = 0;
  int         stable_err = 0;
  logic [7:0] cur_byte   = '0;
  logic [7:0] rx_q[$];
  logic [7:0] pulse_b[$];
  int         pulse_c[$];
  bit         grant_log[$];   // 0 = ALU, 1 = RF

  // Reference expectations
  logic [7:0] exp_b[$];
  bit         exp_g[$];
  bit         last_alu;

  assign bus.tx_busy = model_busy | force_busy;

  always @(negedge clk) begin
    cyc++;
    if (bus.alu_ack) grant_log.push_back(1'b0);
    if (bus.rf_ack)  grant_log.push_back(1'b1);
    if (bus.tx_data_valid) begin
      pulse_b.push_back(bus.tx_p_data);
      pulse_c.push_back(cyc);
    end
    if (model_busy) begin
      if (bus.tx_p_data !== cur_byte) stable_err++;
      if (busy_cnt <= 1) begin
        model_busy = 1'b0;
        busy_cnt   = 0;
      end else begin
        busy_cnt--;
      end
    end else if (bus.tx_data_valid) begin
      if (ignore_cnt > 0) begin
        ignore_cnt--;
      end else begin
        rx_q.push_back(bus.tx_p_data);
        cur_byte   = bus.tx_p_data;
        model_busy = 1'b1;
        busy_cnt   = BUSY_CYC;
      end
    end
  end

  function automatic bit same_b(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit same_g(input bit a[$], input bit b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    rx_q.delete(); pulse_b.delete(); pulse_c.delete(); grant_log.delete();
    exp_b.delete(); exp_g.delete();
    stable_err = 0;
  endtask

  // Reference: which requester is served in what order, and which bytes the
  // UART must finally receive.
  task automatic model_expect(input bit do_alu, input bit do_rf,
                              input logic [15:0] ad, input logic [7:0] rd);
    bit first_alu;
    first_alu = do_alu && (!do_rf || !last_alu);
    if (do_alu && first_alu) begin
      exp_g.push_back(1'b0); exp_b.push_back(ad[7:0]); exp_b.push_back(ad[15:8]);
      last_alu = 1'b1;
    end
    if (do_rf) begin
      exp_g.push_back(1'b1); exp_b.push_back(rd);
      last_alu = 1'b0;
    end
    if (do_alu && !first_alu) begin
      exp_g.push_back(1'b0); exp_b.push_back(ad[7:0]); exp_b.push_back(ad[15:8]);
      last_alu = 1'b1;
    end
  endtask

  task automatic start_req(input bit do_alu, input bit do_rf,
                           input logic [15:0] ad, input logic [7:0] rd);
    model_expect(do_alu, do_rf, ad, rd);
    @(negedge clk);
    bus.alu_req  = do_alu;
    bus.alu_data = ad;
    bus.rf_req   = do_rf;
    bus.rf_data  = rd;
  endtask

  // Holds each request until its ack, then waits for everything to settle.
  task automatic drive_until_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.alu_ack) bus.alu_req = 1'b0;
      if (bus.rf_ack)  bus.rf_req  = 1'b0;
      if (!bus.alu_req && !bus.rf_req && !bus.sched_busy && !bus.tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL %s_timeout: sched_busy=%0b tx_busy=%0b, required idle within 600 cycles",
               nm, bus.sched_busy, bus.tx_busy);
      bus.alu_req = 1'b0;
      bus.rf_req  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_req = 1'b0; bus.alu_data = '0; bus.rf_req = 1'b0; bus.rf_data = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({bus.alu_ack, bus.rf_ack, bus.tx_data_valid, bus.tx_p_data, bus.sched_busy} !== 12'h0) begin
      nerr++;
      $display("FAIL reset_outputs: ack/ack/valid/data/busy=%b, required all 0",
               {bus.alu_ack, bus.rf_ack, bus.tx_data_valid, bus.tx_p_data, bus.sched_busy});
    end
    rst = 1'b0;
    last_alu = 1'b0;
  endtask

  task automatic test_basic();
    clear_logs();
    start_req(1'b1, 1'b0, 16'hA55A, 8'h00);
    @(negedge clk);
    nvec++;
    if (bus.alu_ack !== 1'b1 || bus.sched_busy !== 1'b1) begin
      nerr++;
      $display("FAIL basic_ack_n1: alu_ack=%b sched_busy=%b, required 1 1", bus.alu_ack, bus.sched_busy);
    end
    bus.alu_req = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus.tx_data_valid !== 1'b1 || bus.tx_p_data !== 8'h5A || bus.alu_ack !== 1'b0) begin
      nerr++;
      $display("FAIL basic_issue_n2: valid=%b data=%h ack=%b, required 1 5a 0",
               bus.tx_data_valid, bus.tx_p_data, bus.alu_ack);
    end
    drive_until_idle("basic");
    nvec++;
    if (!same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL basic_bytes: got %p, required %p", rx_q, exp_b);
    end
    nvec++;
    if (pulse_b.size() != 2 || bus.sched_busy !== 1'b0 || stable_err != 0) begin
      nerr++;
      $display("FAIL basic_end: pulses=%0d sched_busy=%b unstable=%0d, required 2 0 0",
               pulse_b.size(), bus.sched_busy, stable_err);
    end
  endtask

  task automatic test_both();
    clear_logs();
    start_req(1'b1, 1'b1, 16'hA55A, 8'h3C);
    drive_until_idle("both1");
    nvec++;
    if (!same_g(grant_log, exp_g) || !same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL both_first: grants %p bytes %p, required %p %p", grant_log, rx_q, exp_g, exp_b);
    end
    // ALU alone, then a tie: RF must win since ALU was served last.
    clear_logs();
    start_req(1'b1, 1'b0, 16'h1234, 8'h00);
    drive_until_idle("both2");
    start_req(1'b1, 1'b1, 16'h5678, 8'hC3);
    drive_until_idle("both3");
    nvec++;
    if (!same_g(grant_log, exp_g) || !same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL both_alternate: grants %p bytes %p, required %p %p", grant_log, rx_q, exp_g, exp_b);
    end
    nvec++;
    if (grant_log.size() < 2 || grant_log[1] != 1'b1) begin
      nerr++;
      $display("FAIL both_rf_not_starved: grant log %p, required RF (1) second", grant_log);
    end
  endtask

  task automatic test_busy_hold();
    bit got;
    clear_logs();
    got = 1'b0;
    force_busy = 1'b1;
    start_req(1'b1, 1'b0, 16'hBEEF, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.alu_ack) begin got = 1'b1; break; end
    end
    bus.alu_req = 1'b0;
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL hold_ack: alu_ack seen=%0b, required 1 while tx_busy held", got);
    end
    repeat (15) @(negedge clk);
    nvec++;
    if (pulse_b.size() != 0 || bus.sched_busy !== 1'b1) begin
      nerr++;
      $display("FAIL hold_no_issue: pulses=%0d sched_busy=%b, required 0 1", pulse_b.size(), bus.sched_busy);
    end
    force_busy = 1'b0;
    drive_until_idle("hold");
    nvec++;
    if (pulse_b.size() != 2 || !same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL hold_release: pulses=%0d bytes %p, required 2 %p", pulse_b.size(), rx_q, exp_b);
    end
  endtask

  task automatic test_retry();
    clear_logs();
    ignore_cnt = 1;
    start_req(1'b1, 1'b0, 16'h7E81, 8'h00);
    drive_until_idle("retry");
    nvec++;
    if (pulse_b.size() != 3) begin
      nerr++;
      $display("FAIL retry_pulses: pulses=%0d, required 3", pulse_b.size());
    end
    nvec++;
    if (pulse_b.size() < 2 || pulse_b[0] !== 8'h81 || pulse_b[1] !== 8'h81) begin
      nerr++;
      $display("FAIL retry_same_byte: pulses %p, required first two 81", pulse_b);
    end
    nvec++;
    if (pulse_c.size() < 2 || (pulse_c[1] - pulse_c[0]) != START_TO + 1) begin
      nerr++;
      $display("FAIL retry_gap: pulse cycles %p, required gap %0d", pulse_c, START_TO + 1);
    end
    nvec++;
    if (!same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL retry_bytes: got %p, required %p", rx_q, exp_b);
    end
  endtask

  task automatic test_reset_mid();
    int npulse;
    clear_logs();
    start_req(1'b1, 1'b0, 16'hD00D, 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.alu_ack) bus.alu_req = 1'b0;
      if (rx_q.size() == 1) break;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({bus.alu_ack, bus.rf_ack, bus.tx_data_valid, bus.tx_p_data, bus.sched_busy} !== 12'h0) begin
      nerr++;
      $display("FAIL rstmid_outputs: ack/ack/valid/data/busy=%b, required all 0",
               {bus.alu_ack, bus.rf_ack, bus.tx_data_valid, bus.tx_p_data, bus.sched_busy});
    end
    rst = 1'b0;
    bus.alu_req = 1'b0;
    last_alu = 1'b0;
    npulse = pulse_b.size();
    repeat (30) @(negedge clk);
    nvec++;
    if (pulse_b.size() != npulse || rx_q.size() != 1) begin
      nerr++;
      $display("FAIL rstmid_dropped: pulses %0d->%0d rx=%0d, required no new pulse and 1 byte",
               npulse, pulse_b.size(), rx_q.size());
    end
    clear_logs();
    start_req(1'b1, 1'b1, 16'h4455, 8'h66);
    drive_until_idle("rstmid");
    nvec++;
    if (!same_g(grant_log, exp_g) || !same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL rstmid_regrant: grants %p bytes %p, required %p %p", grant_log, rx_q, exp_g, exp_b);
    end
  endtask

  task automatic test_drop();
    bit busy_seen;
    clear_logs();
    start_req(1'b1, 1'b0, 16'h0F0F, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.alu_ack) break;
    end
    bus.alu_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.rf_req  = 1'b1;
    bus.rf_data = 8'h99;
    @(negedge clk);
    busy_seen   = bus.sched_busy;
    bus.rf_req  = 1'b0;
    nvec++;
    if (busy_seen !== 1'b1) begin
      nerr++;
      $display("FAIL drop_while_busy: sched_busy=%b during rf pulse, required 1", busy_seen);
    end
    drive_until_idle("drop");
    repeat (5) @(negedge clk);
    nvec++;
    if (!same_g(grant_log, exp_g) || !same_b(rx_q, exp_b)) begin
      nerr++;
      $display("FAIL drop_no_rf: grants %p bytes %p, required %p %p", grant_log, rx_q, exp_g, exp_b);
    end
  endtask

  task automatic test_random();
    int kind;
    logic [15:0] ad;
    logic [7:0]  rd;
    for (int n = 0; n < 12; n++) begin
      clear_logs();
      kind = $urandom_range(0, 2);
      ad   = 16'($urandom);
      rd   = 8'($urandom);
      ignore_cnt = ($urandom_range(0, 3) == 0) ? 1 : 0;
      start_req(kind != 1, kind != 0, ad, rd);
      drive_until_idle("random");
      nvec++;
      if (!same_g(grant_log, exp_g)) begin
        nerr++;
        $display("FAIL random_grants[%0d]: got %p, required %p", n, grant_log, exp_g);
      end
      nvec++;
      if (!same_b(rx_q, exp_b)) begin
        nerr++;
        $display("FAIL random_bytes[%0d]: got %p, required %p", n, rx_q, exp_b);
      end
      nvec++;
      if (stable_err != 0) begin
        nerr++;
        $display("FAIL random_pdata_stable[%0d]: changes while busy=%0d, required 0", n, stable_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both();
    test_busy_hold();
    test_retry();
    test_reset_mid();
    test_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
